serial_deserializer: RTL and testbench

- Serial-in, parallel-out receiver; the receive end of the serial link that UniversalShiftRegister drives when it shifts a loaded word out bit by bit.
- Collects WIDTH serial bits into a word and supports both bit orders, matching the transmitter's shift_left / shift_right modes.
- Presents each completed word on a registered output with a valid/ready handshake.
- Flags a word lost because the consumer stalled.

---
 rtl/serial_deserializer_if.sv | 43 ++++
 rtl/serial_deserializer.sv | 104 ++++++++++
 tb/tb_serial_deserializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_deserializer_if.sv
// Serial receive link and parallel output handshake
// bundled for the serial_deserializer.
interface serial_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             sin_valid;
  logic             sin_data;
  logic             shift_right;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;

  modport slave (
    input  sin_valid,
    input  sin_data,
    input  shift_right,
    input  flush,
    input  out_ready,
    output data_out,
    output out_valid,
    output busy,
    output bit_count,
    output overrun
  );

  modport master (
    output sin_valid,
    output sin_data,
    output shift_right,
    output flush,
    output out_ready,
    input  data_out,
    input  out_valid,
    input  busy,
    input  bit_count,
    input  overrun
  );
endinterface

// File: rtl/serial_deserializer.sv
// Serial-in parallel-out receiver, MSB- or LSB-first,
// registered word output with valid/ready and overrun flag.
module serial_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic reset,
  serial_deserializer_if.slave sd
);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_sr, w_sr_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             r_dir, w_dir_n;
  logic [WIDTH-1:0] r_data, w_data_n;
  logic             r_ov, w_ov_n;
  logic             r_orun, w_orun_n;

  logic             w_accept;
  logic             w_dir;
  logic             w_last;
  logic [WIDTH-1:0] w_ins;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_data  <= '0;
      r_ov    <= 1'b0;
      r_orun  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sr    <= w_sr_n;
      r_cnt   <= w_cnt_n;
      r_dir   <= w_dir_n;
      r_data  <= w_data_n;
      r_ov    <= w_ov_n;
      r_orun  <= w_orun_n;
    end
  end

  // bit order is latched on the first bit only
  assign w_accept = sd.sin_valid & ~sd.flush;
  assign w_dir    = (r_state == S_IDLE) ?
                    sd.shift_right : r_dir;
  assign w_ins    = w_dir ?
    {sd.sin_data, r_sr[WIDTH-1:1]} :
    {r_sr[WIDTH-2:0], sd.sin_data};
  assign w_last   = w_accept &&
                    (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_n = r_state;
    w_sr_n    = r_sr;
    w_cnt_n   = r_cnt;
    w_dir_n   = r_dir;
    w_data_n  = r_data;
    w_ov_n    = r_ov;
    w_orun_n  = 1'b0;

    if (sd.flush) begin
      w_state_n = S_IDLE;
      w_sr_n    = '0;
      w_cnt_n   = '0;
    end else if (w_accept) begin
      w_dir_n = w_dir;
      w_sr_n  = w_ins;
      if (w_last) begin
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end else begin
        w_cnt_n   = r_cnt + CNT_W'(1);
        w_state_n = S_ACCUM;
      end
    end

    // a stalled consumer keeps the old word
    if (w_last) begin
      if (!r_ov || sd.out_ready) begin
        w_data_n = w_ins;
        w_ov_n   = 1'b1;
      end else begin
        w_orun_n = 1'b1;
      end
    end else if (r_ov && sd.out_ready) begin
      w_ov_n = 1'b0;
    end
  end

  assign sd.data_out  = r_data;
  assign sd.out_valid = r_ov;
  assign sd.overrun   = r_orun;
  assign sd.bit_count = r_cnt;
  assign sd.busy      = (r_cnt != '0);

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer with a
// scoreboard of expected words.
module tb_serial_deserializer;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  serial_deserializer_if #(.WIDTH(W)) sd ();

  serial_deserializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .sd    (sd.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_err;
  logic [W-1:0] sb[$];
  logic [W-1:0] held;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(
    input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = v[W-1-k];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [W-1:0] seq,
                          input logic dir,
                          input bit toggle,
                          input bit drop,
                          input bit ready_last);
    logic [W-1:0] exp;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      sd.sin_valid   = 1'b1;
      sd.sin_data    = seq[W-1-i];
      sd.shift_right = (toggle && i >= 3) ? ~dir : dir;
      if (i == W - 1 && ready_last) sd.out_ready = 1'b1;
      step();
      sd.sin_valid = 1'b0;
      if (i < W - 1)
        chk("bit_count", 32'(sd.bit_count), 32'(i + 1));
    end
    exp = dir ? rev(seq) : seq;
    if (!drop) begin
      sb.push_back(exp);
      held = exp;
      chk("data_out", 32'(sd.data_out),
          32'(sb.pop_front()));
      chk("overrun_lo", 32'(sd.overrun), 0);
    end else begin
      chk("data_held", 32'(sd.data_out), 32'(held));
      chk("overrun_hi", 32'(sd.overrun), 1);
    end
    chk("out_valid", 32'(sd.out_valid), 1);
    chk("cnt_wrap", 32'(sd.bit_count), 0);
    chk("busy_lo", 32'(sd.busy), 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    held  = '0;
    rst_n = 1'b0;
    sd.sin_valid   = 1'b0;
    sd.sin_data    = 1'b0;
    sd.shift_right = 1'b0;
    sd.flush       = 1'b0;
    sd.out_ready   = 1'b0;

    step();
    step();
    chk("rst_data", 32'(sd.data_out), 0);
    chk("rst_valid", 32'(sd.out_valid), 0);
    chk("rst_cnt", 32'(sd.bit_count), 0);
    chk("rst_busy", 32'(sd.busy), 0);
    chk("rst_orun", 32'(sd.overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // MSB-first, consumer ready
    sd.out_ready = 1'b1;
    send_seq(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("drain_valid", 32'(sd.out_valid), 0);
    chk("drain_data", 32'(sd.data_out), 32'h0AA);

    // LSB-first, plain then with mid-word toggle
    send_seq(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    send_seq(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("lsb_drain", 32'(sd.out_valid), 0);

    // backpressure and overrun
    sd.out_ready = 1'b0;
    send_seq(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    send_seq(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("orun_pulse", 32'(sd.overrun), 0);
    chk("bp_data", 32'(sd.data_out), 32'h0AA);
    chk("bp_valid", 32'(sd.out_valid), 1);
    @(negedge clk);
    sd.out_ready = 1'b1;
    step();
    chk("bp_drain", 32'(sd.out_valid), 0);

    // drain and completion on the same edge
    @(negedge clk);
    sd.out_ready = 1'b0;
    send_seq(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    send_seq(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("sim_drain", 32'(sd.out_valid), 0);

    // gaps and flush
    @(negedge clk);
    sd.sin_valid = 1'b1;
    sd.sin_data  = 1'b1;
    step();
    sd.sin_valid = 1'b0;
    repeat (3) step();
    chk("gap_cnt", 32'(sd.bit_count), 1);
    @(negedge clk);
    sd.sin_valid = 1'b1;
    step();
    sd.sin_valid = 1'b0;
    chk("gap_cnt2", 32'(sd.bit_count), 2);
    chk("gap_busy", 32'(sd.busy), 1);
    @(negedge clk);
    sd.flush     = 1'b1;
    sd.sin_valid = 1'b1;
    step();
    sd.flush     = 1'b0;
    sd.sin_valid = 1'b0;
    chk("flush_cnt", 32'(sd.bit_count), 0);
    chk("flush_busy", 32'(sd.busy), 0);
    chk("flush_ov", 32'(sd.out_valid), 0);
    send_seq(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // reset in the middle of a word
    sd.out_ready = 1'b0;
    send_seq(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sd.sin_valid = 1'b1;
      sd.sin_data  = i[0];
      step();
      sd.sin_valid = 1'b0;
    end
    chk("pre_rst_cnt", 32'(sd.bit_count), 5);
    @(negedge clk);
    rst_n = 1'b0;
    step();
    chk("mid_rst_cnt", 32'(sd.bit_count), 0);
    chk("mid_rst_ov", 32'(sd.out_valid), 0);
    chk("mid_rst_data", 32'(sd.data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sd.out_ready = 1'b1;
    send_seq(8'h1E, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lsb_1e", 32'(sd.data_out), 32'h078);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
